// File: rtl/servo_ctrl_pkg.sv
// rtl/servo_ctrl_pkg.sv - shared state type, widths and ramp helper for servo_ctrl
package servo_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int RATIO_W   = 8;
  localparam int COUNT_MAX = 255;

  // The step is clamped to the remaining distance, so the result always lies
  // between cur and target and can never wrap.
  function automatic logic [RATIO_W-1:0] ramp_next(
    input logic [RATIO_W-1:0] cur,
    input logic [RATIO_W-1:0] target,
    input logic [RATIO_W-1:0] step
  );
    logic [RATIO_W-1:0] diff;
    diff      = '0;
    ramp_next = cur;
    if (cur < target) begin
      diff      = target - cur;
      ramp_next = cur + ((diff > step) ? step : diff);
    end else if (cur > target) begin
      diff      = cur - target;
      ramp_next = cur - ((diff > step) ? step : diff);
    end
  endfunction

endpackage

// File: rtl/servo_ctrl_pwm_gen.sv
// rtl/servo_ctrl_pwm_gen.sv - prescaler, 8-bit PWM counter and comparator with period-end strobe
module servo_ctrl_pwm_gen
  import servo_ctrl_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_run,
  input  logic [RATIO_W-1:0] i_ratio,
  output logic               o_pwm,
  output logic               o_period_end
);

  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PSW-1:0]     r_presc;
  logic [RATIO_W-1:0] r_count;
  logic               r_pwm;
  logic               w_presc_wrap;

  assign w_presc_wrap = (r_presc == PSW'(PRESCALE - 1));
  assign o_period_end = i_run && w_presc_wrap && (r_count == RATIO_W'(COUNT_MAX));
  assign o_pwm        = r_pwm;

  // Dropping i_run clears everything, so a new run always starts at count 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_count <= '0;
      r_pwm   <= 1'b0;
    end else if (!i_run) begin
      r_presc <= '0;
      r_count <= '0;
      r_pwm   <= 1'b0;
    end else begin
      r_pwm <= (r_count < i_ratio);
      if (w_presc_wrap) begin
        r_presc <= '0;
        r_count <= r_count + RATIO_W'(1);
      end else begin
        r_presc <= r_presc + PSW'(1);
      end
    end
  end

endmodule

// File: rtl/servo_ctrl.sv
// rtl/servo_ctrl.sv - servo PWM controller: enable FSM and duty-ratio slew toward target
module servo_ctrl
  import servo_ctrl_pkg::*;
#(
  parameter int PRESCALE     = 4,
  parameter int RAMP_STEP    = 1,
  parameter int RAMP_PERIODS = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               pwm_enable,
  input  logic [RATIO_W-1:0] start_pwm_ratio,
  input  logic [RATIO_W-1:0] target_pwm_ratio,
  output logic               pwm_signal
);

  localparam int PCW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  state_t             r_state, w_state_next;
  logic [RATIO_W-1:0] r_cur, w_cur_next;
  logic [PCW-1:0]     r_pcnt, w_pcnt_next;
  logic               w_run;
  logic               w_period_end;

  // Enable/disable transitions take priority over a coincident period end.
  assign w_run = (r_state == RUN) && pwm_enable;

  servo_ctrl_pwm_gen #(
    .PRESCALE(PRESCALE)
  ) u_pwm_gen (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_run       (w_run),
    .i_ratio     (r_cur),
    .o_pwm       (pwm_signal),
    .o_period_end(w_period_end)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cur   <= w_cur_next;
      r_pcnt  <= w_pcnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cur_next   = r_cur;
    w_pcnt_next  = r_pcnt;
    case (r_state)
      IDLE: begin
        if (pwm_enable) begin
          w_state_next = RUN;
          w_cur_next   = start_pwm_ratio;
          w_pcnt_next  = '0;
        end
      end
      RUN: begin
        if (!pwm_enable) begin
          w_state_next = IDLE;
          w_pcnt_next  = '0;
        end else if (w_period_end) begin
          if (r_pcnt == PCW'(RAMP_PERIODS - 1)) begin
            w_pcnt_next = '0;
            w_cur_next  = ramp_next(r_cur, target_pwm_ratio, RATIO_W'(RAMP_STEP));
          end else begin
            w_pcnt_next = r_pcnt + PCW'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_servo_ctrl.sv
// tb/tb_servo_ctrl.sv - self-checking bench for servo_ctrl (two parameter sets)
module tb_servo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en_a, en_b;
  logic [7:0] start_a, start_b, tgt_a, tgt_b;
  logic       pwm_a, pwm_b;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state per instance: 0 = A (PRESCALE 1, step 1, every period), 1 = B (PRESCALE 4, step 7, every 3 periods)
  int   m_p[2]    = '{1, 4};
  int   m_step[2] = '{1, 7};
  int   m_rp[2]   = '{1, 3};
  bit   m_run[2];
  int   m_t[2];
  int   m_ratio[2];
  logic m_exp[2];

  servo_ctrl #(.PRESCALE(1), .RAMP_STEP(1), .RAMP_PERIODS(1)) u_dut_a (
    .clock           (clk),
    .reset_n         (rst_n),
    .pwm_enable      (en_a),
    .start_pwm_ratio (start_a),
    .target_pwm_ratio(tgt_a),
    .pwm_signal      (pwm_a)
  );

  servo_ctrl #(.PRESCALE(4), .RAMP_STEP(7), .RAMP_PERIODS(3)) u_dut_b (
    .clock           (clk),
    .reset_n         (rst_n),
    .pwm_enable      (en_b),
    .start_pwm_ratio (start_b),
    .target_pwm_ratio(tgt_b),
    .pwm_signal      (pwm_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int toward(input int c, input int t, input int s);
    if (c < t) return c + (((t - c) < s) ? (t - c) : s);
    if (c > t) return c - (((c - t) < s) ? (c - t) : s);
    return c;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic measure(input int which, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      hi += (which == 0) ? int'(pwm_a) : int'(pwm_b);
    end
  endtask

  // Model update at each rising edge: output after edge k of a run reflects
  // clock k-1 of the run; high while the in-period position is below ratio*PRESCALE.
  task automatic model_step();
    logic en_i;
    int   st_i, tg_i, per;
    for (int i = 0; i < 2; i++) begin
      en_i = (i == 0) ? en_a : en_b;
      st_i = (i == 0) ? int'(start_a) : int'(start_b);
      tg_i = (i == 0) ? int'(tgt_a) : int'(tgt_b);
      per  = 256 * m_p[i];
      if (!rst_n) begin
        m_run[i] = 0; m_t[i] = 0; m_ratio[i] = 0; m_exp[i] = 1'b0;
      end else if (!m_run[i]) begin
        m_exp[i] = 1'b0;
        if (en_i) begin
          m_run[i] = 1; m_ratio[i] = st_i; m_t[i] = 0;
        end
      end else if (!en_i) begin
        m_run[i] = 0; m_exp[i] = 1'b0;
      end else begin
        m_exp[i] = ((m_t[i] % per) < m_ratio[i] * m_p[i]);
        m_t[i]++;
        if ((m_t[i] % per) == 0 && ((m_t[i] / per) % m_rp[i]) == 0)
          m_ratio[i] = toward(m_ratio[i], tg_i, m_step[i]);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0; en_b = 1'b0;
    start_a = '0; start_b = '0; tgt_a = '0; tgt_b = '0;

    fork
      forever begin
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (rst_n) begin
          for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (((i == 0) ? pwm_a : pwm_b) !== m_exp[i]) begin
              n_fails++;
              if (n_fails < 20)
                $display("FAIL cycle_pwm_%0d at %0t: got %b, expected %b", i, $time,
                         (i == 0) ? pwm_a : pwm_b, m_exp[i]);
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("reset_pwm_a", int'(pwm_a), 0);
    check("reset_pwm_b", int'(pwm_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    fork
      begin : seq_a
        int hi;
        start_a = 8'd20; tgt_a = 8'd0; en_a = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 115; k++) begin
          if (k == 21) tgt_a = 8'd50;
          if (k == 73) tgt_a = 8'd10;
          measure(0, 256, hi);
          case (k)
            0:   check("a_period0", hi, 20);
            1:   check("a_period1", hi, 19);
            19:  check("a_period19", hi, 1);
            20:  check("a_period20_low", hi, 0);
            22:  check("a_rise_first", hi, 1);
            71:  check("a_rise_reach50", hi, 50);
            72:  check("a_rise_hold50", hi, 50);
            74:  check("a_fall_first", hi, 49);
            113: check("a_fall_reach10", hi, 10);
            114: check("a_fall_hold10", hi, 10);
            default: ;
          endcase
        end
      end
      begin : seq_b
        int hi;
        start_b = 8'd20; tgt_b = 8'd50; en_b = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 21; k++) begin
          if (k == 19) tgt_b = 8'd20;
          measure(1, 1024, hi);
          case (k)
            0:  check("b_period0", hi, 80);
            2:  check("b_period2", hi, 80);
            3:  check("b_ratio27", hi, 108);
            6:  check("b_ratio34", hi, 136);
            9:  check("b_ratio41", hi, 164);
            12: check("b_ratio48", hi, 192);
            15: check("b_ratio50", hi, 200);
            18: check("b_no_overshoot", hi, 200);
            20: check("b_reverse_pending", hi, 200);
            default: ;
          endcase
        end
        repeat (50) @(negedge clk);
        check("b_high_before_disable", int'(pwm_b), 1);
        en_b = 1'b0;
        @(negedge clk);
        check("b_low_after_disable", int'(pwm_b), 0);
        repeat (5) @(negedge clk);
        start_b = 8'd100; tgt_b = 8'd100; en_b = 1'b1;
        @(negedge clk);
        measure(1, 1024, hi);
        check("b_reenable_400", hi, 400);
      end
    join

    begin : seq_reset
      int hi;
      en_a = 1'b0;
      repeat (2) @(negedge clk);
      start_a = 8'd30; tgt_a = 8'd30; en_a = 1'b1;
      repeat (10) @(negedge clk);
      check("a_high_before_reset", int'(pwm_a), 1);
      #2 rst_n = 1'b0;
      #1 check("a_async_reset_low", int'(pwm_a), 0);
      @(negedge clk);
      en_a = 1'b0; en_b = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(negedge clk);
      check("a_idle_after_reset", int'(pwm_a), 0);
      start_a = 8'd5; tgt_a = 8'd5; en_a = 1'b1;
      @(negedge clk);
      measure(0, 256, hi);
      check("a_after_reset_enable", hi, 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
